// File: rtl/duty_cmd_uart_rx.sv
// 8N1 UART receiver and 4-byte duty command parser (A5, CMD, DUTY, CSUM) for the PWM generator.
// Accepted packets load duty_n/sel with a one-cycle update strobe; rejected ones pulse pkt_err.
module duty_cmd_uart_rx #(
    parameter int CLK_HZ       = 10_000_000,
    parameter int BAUD         = 9600,
    parameter int DUTY_MAX     = 127,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] duty_n,
    output logic       sel,
    output logic       update,
    output logic       pkt_err,
    output logic       busy
);
    localparam int OSR_DIV  = CLK_HZ / (BAUD * 16);
    localparam int DIV_W    = $clog2(OSR_DIV + 1);
    localparam int TO_TICKS = TIMEOUT_BITS * 16;
    localparam int TO_W     = $clog2(TO_TICKS + 1);
    localparam logic [7:0] HDR      = 8'hA5;
    localparam logic [7:0] DUTY_CAP = 8'(DUTY_MAX);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {P_HUNT, P_CMD, P_DUTY, P_CSUM} p_state_t;

    logic rx_meta, rx_s, rx_q, fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    assign fall = rx_q & ~rx_s;

    // Oversampling divider restarts on a start edge so bit sampling is phase-locked to it
    rx_state_t        rs, rs_nx;
    logic [DIV_W-1:0] div_cnt;
    logic             tick, start_det;

    assign start_det = (rs == R_IDLE) && fall;
    assign tick      = (div_cnt == DIV_W'(OSR_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (start_det || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    logic [3:0] tick_cnt, tick_cnt_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [7:0] shreg, shreg_nx;
    logic       byte_valid, byte_valid_nx;
    logic       frame_err, frame_err_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs         <= R_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rs         <= rs_nx;
            tick_cnt   <= tick_cnt_nx;
            bit_cnt    <= bit_cnt_nx;
            shreg      <= shreg_nx;
            byte_valid <= byte_valid_nx;
            frame_err  <= frame_err_nx;
        end
    end

    always_comb begin
        rs_nx         = rs;
        tick_cnt_nx   = tick_cnt;
        bit_cnt_nx    = bit_cnt;
        shreg_nx      = shreg;
        byte_valid_nx = 1'b0;
        frame_err_nx  = 1'b0;
        case (rs)
            R_IDLE: begin
                if (fall) begin
                    rs_nx       = R_START;
                    tick_cnt_nx = '0;
                end
            end
            R_START: begin
                // 8th tick lands mid start bit; high there means a glitch
                if (tick) begin
                    if (tick_cnt == 4'd7) begin
                        tick_cnt_nx = '0;
                        bit_cnt_nx  = '0;
                        rs_nx       = rx_s ? R_IDLE : R_DATA;
                    end else begin
                        tick_cnt_nx = tick_cnt + 4'd1;
                    end
                end
            end
            R_DATA: begin
                if (tick) begin
                    tick_cnt_nx = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shreg_nx   = {rx_s, shreg[7:1]};
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            rs_nx = R_STOP;
                    end
                end
            end
            R_STOP: begin
                if (tick) begin
                    tick_cnt_nx = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        rs_nx         = R_IDLE;
                        byte_valid_nx = rx_s;
                        frame_err_nx  = ~rx_s;
                    end
                end
            end
            default: rs_nx = R_IDLE;
        endcase
    end

    p_state_t        ps, ps_nx;
    logic [7:0]      cmd_r, cmd_nx, duty_r, duty_nx, csum_r, csum_nx;
    logic            chk_pend, chk_pend_nx;
    logic [TO_W-1:0] to_cnt, to_cnt_nx;
    logic [7:0]      duty_n_nx;
    logic            sel_nx, update_nx, pkt_err_nx, timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps       <= P_HUNT;
            cmd_r    <= '0;
            duty_r   <= '0;
            csum_r   <= '0;
            chk_pend <= 1'b0;
            to_cnt   <= '0;
            duty_n   <= '0;
            sel      <= 1'b0;
            update   <= 1'b0;
            pkt_err  <= 1'b0;
        end else begin
            ps       <= ps_nx;
            cmd_r    <= cmd_nx;
            duty_r   <= duty_nx;
            csum_r   <= csum_nx;
            chk_pend <= chk_pend_nx;
            to_cnt   <= to_cnt_nx;
            duty_n   <= duty_n_nx;
            sel      <= sel_nx;
            update   <= update_nx;
            pkt_err  <= pkt_err_nx;
        end
    end

    assign timeout = (ps != P_HUNT) && tick && (to_cnt == TO_W'(TO_TICKS - 1));

    // The CSUM byte is judged one clock after it arrives; the parser stays in
    // CSUM until then so busy drops on the same edge that raises update.
    always_comb begin
        ps_nx       = ps;
        cmd_nx      = cmd_r;
        duty_nx     = duty_r;
        csum_nx     = csum_r;
        chk_pend_nx = 1'b0;
        duty_n_nx   = duty_n;
        sel_nx      = sel;
        update_nx   = 1'b0;
        pkt_err_nx  = 1'b0;
        to_cnt_nx   = to_cnt;

        if (ps == P_HUNT || byte_valid)
            to_cnt_nx = '0;
        else if (tick)
            to_cnt_nx = to_cnt + 1'b1;

        if (frame_err) begin
            ps_nx      = P_HUNT;
            pkt_err_nx = 1'b1;
        end else if (chk_pend) begin
            ps_nx = P_HUNT;
            if (csum_r == (HDR ^ cmd_r ^ duty_r) && cmd_r[7:1] == 7'd0) begin
                update_nx = 1'b1;
                sel_nx    = cmd_r[0];
                duty_n_nx = (duty_r > DUTY_CAP) ? DUTY_CAP : duty_r;
            end else begin
                pkt_err_nx = 1'b1;
            end
        end else if (byte_valid) begin
            case (ps)
                P_HUNT: if (shreg == HDR) ps_nx = P_CMD;
                P_CMD: begin
                    cmd_nx = shreg;
                    ps_nx  = P_DUTY;
                end
                P_DUTY: begin
                    duty_nx = shreg;
                    ps_nx   = P_CSUM;
                end
                P_CSUM: begin
                    csum_nx     = shreg;
                    chk_pend_nx = 1'b1;
                end
                default: ps_nx = P_HUNT;
            endcase
        end else if (timeout) begin
            ps_nx      = P_HUNT;
            pkt_err_nx = 1'b1;
        end
    end

    assign busy = (ps != P_HUNT);

endmodule
